// File: rtl/operand_mux_arb.sv
// operand_mux_arb: registered N-channel operand selector with a
// valid/ready output slot, direct-select and round-robin capture modes.
module operand_mux_arb #(
    parameter int WIDTH = 16,
    parameter int N     = 6,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_req,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic                 load,
    output logic [N-1:0]         grant,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    localparam logic [SELW:0]   NUM  = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N-1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             slot_free;
    logic             sel_ok;
    logic             found;
    logic [SELW-1:0]  win;
    logic [SELW:0]    idx;
    logic             cap_dir;
    logic             cap_rr;
    logic             cap;
    logic [SELW-1:0]  cap_chan;
    logic [WIDTH-1:0] mux_data;

    assign slot_free = !out_valid_q || out_ready;
    assign sel_ok    = ({1'b0, sel} < NUM);
    assign cap_dir   = !mode && load && slot_free;
    assign cap_rr    = mode && found && slot_free;
    assign cap       = cap_dir || cap_rr;
    assign cap_chan  = mode ? win : sel;

    // Round-robin scan: first requester at or after ptr, wrapping at N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (SELW+1)'(k);
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!found && in_req[idx[SELW-1:0]]) begin
                found = 1'b1;
                win   = idx[SELW-1:0];
            end
        end
    end

    // Data mux keyed by channel index; an out-of-range code yields zero.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (cap_chan == SELW'(i)) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot grant for the channel captured at this edge; never in reset.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = rst_n && cap
                       && (cap_rr || sel_ok)
                       && (cap_chan == SELW'(i));
        end
    end

    // Next state of the output slot and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        sel_err_d   = sel_err_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (cap) begin
            out_data_d  = mux_data;
            out_chan_d  = cap_chan;
            sel_err_d   = cap_dir && !sel_ok;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (cap_rr) begin
            ptr_d = (win == LAST) ? '0 : win + 1'b1;
        end
    end

    // Output slot and pointer registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_operand_mux_arb.sv
// Bench for operand_mux_arb: reference model predicts each capture and
// queues the expected word; the held output is compared every cycle.
module tb_operand_mux_arb;

    localparam int W    = 16;
    localparam int N    = 6;
    localparam int SELW = 3;

    typedef struct packed {
        logic [W-1:0]    d;
        logic [SELW-1:0] c;
        logic            e;
    } word_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_req;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic              load;
    logic [N-1:0]      grant;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_chan;
    logic              out_valid;
    logic              out_ready;
    logic              sel_err;

    int checks   = 0;
    int failures = 0;

    word_t q[$];
    logic  m_valid;
    int    m_ptr;

    always #5 clk = ~clk;

    operand_mux_arb #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_req   (in_req),
        .mode     (mode),
        .sel      (sel),
        .load     (load),
        .grant    (grant),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: predict at negedge, check held word and grant,
    // update scoreboard, then return 1ns after the rising edge.
    task automatic cyc();
        logic       slot;
        logic       capd;
        logic [N-1:0] eg;
        word_t      w;
        int         k;
        int         j;
        @(negedge clk);
        chk("valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid && q.size() > 0) begin
            chk("data", {16'b0, out_data}, {16'b0, q[0].d});
            chk("chan", {29'b0, out_chan}, {29'b0, q[0].c});
            chk("err", {31'b0, sel_err}, {31'b0, q[0].e});
        end
        slot = !m_valid || out_ready;
        capd = 1'b0;
        eg   = '0;
        w    = '0;
        if (rst_n) begin
            if (!mode) begin
                if (load && slot) begin
                    capd = 1'b1;
                    w.c  = sel;
                    if (int'(sel) < N) begin
                        w.d = in_data[int'(sel)*W +: W];
                        eg[sel] = 1'b1;
                    end else begin
                        w.e = 1'b1;
                    end
                end
            end else if (in_req != 0 && slot) begin
                k = 0;
                j = m_ptr;
                while (!in_req[j] && k < N) begin
                    j = (j + 1) % N;
                    k++;
                end
                capd  = 1'b1;
                w.c   = SELW'(j);
                w.d   = in_data[j*W +: W];
                eg[j] = 1'b1;
                m_ptr = (j + 1) % N;
            end
        end
        chk("grant", {26'b0, grant}, {26'b0, eg});
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else begin
            if (m_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (capd) begin
                q.push_back(w);
            end
            m_valid = capd ? 1'b1 : (out_ready ? 1'b0 : m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    int rr_all[7] = '{0, 1, 2, 3, 4, 5, 0};
    int rr_two[4] = '{2, 5, 2, 5};

    initial begin
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = 16'h1000 + W'(i);
        end
        m_valid   = 1'b0;
        m_ptr     = 0;
        rst_n     = 1'b0;
        load      = 1'b1;
        in_req    = '1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_data", {16'b0, out_data}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);

        rst_n = 1'b1;
        mode  = 1'b1;
        load  = 1'b0;
        cyc();
        chk("rst_first_rr", {29'b0, out_chan}, 32'd0);

        mode = 1'b0;
        load = 1'b1;
        for (int s = 0; s < N; s++) begin
            sel = SELW'(s);
            cyc();
            chk("dir_data", {16'b0, out_data}, 32'h1000 + s);
        end

        sel = 3'd6;
        cyc();
        chk("oor6_err", {31'b0, sel_err}, 32'd1);
        sel = 3'd7;
        cyc();
        chk("oor7_data", {16'b0, out_data}, 32'h0);
        sel = 3'd2;
        cyc();
        chk("oor_recover", {16'b0, out_data}, 32'h1002);

        sel = 3'd3;
        cyc();
        out_ready = 1'b0;
        sel = 3'd1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_hold", {16'b0, out_data}, 32'h1003);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release", {16'b0, out_data}, 32'h1001);

        rst_n = 1'b0;
        cyc();
        rst_n  = 1'b1;
        mode   = 1'b1;
        load   = 1'b0;
        in_req = 6'b111111;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("rr_all", {29'b0, out_chan}, 32'(rr_all[i]));
        end
        in_req = 6'b100100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_two", {29'b0, out_chan}, 32'(rr_two[i]));
        end

        rst_n = 1'b0;
        cyc();
        rst_n  = 1'b1;
        in_req = 6'b111111;
        cyc();
        chk("ms_w0", {29'b0, out_chan}, 32'd0);
        cyc();
        chk("ms_w1", {29'b0, out_chan}, 32'd1);
        mode = 1'b0;
        load = 1'b1;
        sel  = 3'd4;
        cyc();
        chk("ms_dir", {16'b0, out_data}, 32'h1004);
        mode = 1'b1;
        cyc();
        chk("ms_ptr", {29'b0, out_chan}, 32'd2);
        out_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("ms_rst_valid", {31'b0, out_valid}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("ms_rst_win", {29'b0, out_chan}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            mode      = 1'($urandom_range(1));
            sel       = SELW'($urandom_range(7));
            load      = 1'($urandom_range(1));
            in_req    = N'($urandom_range(63));
            out_ready = ($urandom_range(3) != 0);
            rst_n     = ($urandom_range(31) != 0);
            cyc();
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
